// File: rtl/rd_ptr_empty.sv
// Read-domain pointer and status block of a dual-clock FIFO: binary/Gray read
// pointers, registered empty, almost-empty, fill level and sticky underflow.
module rd_ptr_empty #(
    parameter int ADDRSIZE  = 4,
    parameter int AE_THRESH = 2
) (
    input  logic                rd_clk,
    input  logic                rd_rst_n,
    input  logic                rd_en,
    input  logic [ADDRSIZE:0]   rq2_wr_ptr,
    input  logic                underflow_clr,
    output logic [ADDRSIZE-1:0] rd_addr,
    output logic [ADDRSIZE:0]   rd_grayptr,
    output logic                rd_empty,
    output logic                rd_almost_empty,
    output logic [ADDRSIZE:0]   rd_level,
    output logic                rd_underflow
);

    localparam int PW = ADDRSIZE + 1;
    localparam logic [PW-1:0] AE_LIMIT = PW'(AE_THRESH);

    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return (b >> 1) ^ b;
    endfunction

    // XOR-prefix from the MSB down recovers the binary count.
    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [PW-1:0] rd_ptr_q,   rd_ptr_d;
    logic [PW-1:0] rd_gray_q,  rd_gray_d;
    logic          empty_q,    empty_d;
    logic          aempty_q,   aempty_d;
    logic [PW-1:0] level_q,    level_d;
    logic          underflow_q, underflow_d;

    logic          rd_inc_s;
    logic [PW-1:0] wr_bin_s;

    // Next-state computation for pointers and status flags.
    always_comb begin
        rd_inc_s  = rd_en & ~empty_q;
        rd_ptr_d  = rd_ptr_q + {{(PW-1){1'b0}}, rd_inc_s};
        rd_gray_d = bin2gray(rd_ptr_d);
        wr_bin_s  = gray2bin(rq2_wr_ptr);
        level_d   = wr_bin_s - rd_ptr_d;
        empty_d   = (rd_gray_d == rq2_wr_ptr);
        aempty_d  = (level_d <= AE_LIMIT);
        // A read attempt while empty beats a concurrent clear.
        if (rd_en && empty_q) begin
            underflow_d = 1'b1;
        end else if (underflow_clr) begin
            underflow_d = 1'b0;
        end else begin
            underflow_d = underflow_q;
        end
    end

    // State registers; reset leaves the FIFO looking empty.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            rd_ptr_q    <= {PW{1'b0}};
            rd_gray_q   <= {PW{1'b0}};
            empty_q     <= 1'b1;
            aempty_q    <= 1'b1;
            level_q     <= {PW{1'b0}};
            underflow_q <= 1'b0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            rd_gray_q   <= rd_gray_d;
            empty_q     <= empty_d;
            aempty_q    <= aempty_d;
            level_q     <= level_d;
            underflow_q <= underflow_d;
        end
    end

    assign rd_addr         = rd_ptr_q[ADDRSIZE-1:0];
    assign rd_grayptr      = rd_gray_q;
    assign rd_empty        = empty_q;
    assign rd_almost_empty = aempty_q;
    assign rd_level        = level_q;
    assign rd_underflow    = underflow_q;

endmodule

// File: tb/tb_rd_ptr_empty.sv
// Self-checking bench for rd_ptr_empty: directed steps plus a randomized wrap
// phase, compared against a word-count model of the FIFO read side.
module tb_rd_ptr_empty;

    logic       rd_clk;
    logic       rd_rst_n;
    logic       rd_en;
    logic [4:0] rq2_wr_ptr;
    logic       underflow_clr;
    logic [3:0] rd_addr;
    logic [4:0] rd_grayptr;
    logic       rd_empty;
    logic       rd_almost_empty;
    logic [4:0] rd_level;
    logic       rd_underflow;

    rd_ptr_empty #(.ADDRSIZE(4), .AE_THRESH(2)) dut (
        .rd_clk          (rd_clk),
        .rd_rst_n        (rd_rst_n),
        .rd_en           (rd_en),
        .rq2_wr_ptr      (rq2_wr_ptr),
        .underflow_clr   (underflow_clr),
        .rd_addr         (rd_addr),
        .rd_grayptr      (rd_grayptr),
        .rd_empty        (rd_empty),
        .rd_almost_empty (rd_almost_empty),
        .rd_level        (rd_level),
        .rd_underflow    (rd_underflow)
    );

    initial rd_clk = 1'b0;
    always #5 rd_clk = ~rd_clk;

    int checks = 0;
    int failures = 0;

    // Model: words written / read counted modulo 32, flags derived from occupancy.
    int m_w, m_r, m_lvl, m_empty, m_uf, last_acc;
    int tot_wr, tot_rd;

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        checks++;
        assert (obs === 32'(exp)) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_addr"},   32'(rd_addr),         m_r % 16);
        chk({tag, "_gray"},   32'(rd_grayptr),      m_r ^ (m_r >> 1));
        chk({tag, "_empty"},  32'(rd_empty),        m_empty);
        chk({tag, "_aempty"}, 32'(rd_almost_empty), (m_lvl <= 2) ? 1 : 0);
        chk({tag, "_level"},  32'(rd_level),        m_lvl);
        chk({tag, "_uflow"},  32'(rd_underflow),    m_uf);
    endtask

    task automatic set_w(input int w);
        m_w = w % 32;
        rq2_wr_ptr = 5'(m_w ^ (m_w >> 1));
    endtask

    task automatic model_reset();
        m_r = 0; m_lvl = 0; m_empty = 1; m_uf = 0; tot_wr = 0; tot_rd = 0;
    endtask

    task automatic step(input bit en, input bit clr, input string tag);
        rd_en = en;
        underflow_clr = clr;
        @(posedge rd_clk);
        last_acc = (en && m_empty == 0) ? 1 : 0;
        if (en && m_empty == 1) m_uf = 1;
        else if (clr) m_uf = 0;
        m_r = (m_r + last_acc) % 32;
        tot_rd += last_acc;
        m_lvl = (m_w - m_r + 32) % 32;
        m_empty = (m_lvl == 0) ? 1 : 0;
        #1;
        check_all(tag);
        rd_en = 1'b0;
        underflow_clr = 1'b0;
    endtask

    task automatic hard_reset();
        @(negedge rd_clk);
        rd_rst_n = 1'b0;
        set_w(0);
        model_reset();
        @(negedge rd_clk);
        rd_rst_n = 1'b1;
    endtask

    initial begin
        logic [4:0] prev_g;
        int wp;
        rd_rst_n = 1'b0;
        rd_en = 1'b0;
        underflow_clr = 1'b0;
        set_w(0);
        model_reset();
        #12;
        check_all("por");
        @(negedge rd_clk);
        rd_rst_n = 1'b1;

        // Reset mid-stream with five words pending.
        set_w(5); tot_wr = 5;
        step(1'b0, 1'b0, "lvl5");
        #2;
        rd_rst_n = 1'b0;
        set_w(0);
        model_reset();
        #1;
        check_all("async_rst");
        @(negedge rd_clk);
        rd_rst_n = 1'b1;

        // Single word in, single word out.
        set_w(1); tot_wr = 1;
        step(1'b0, 1'b0, "one_in");
        step(1'b1, 1'b0, "one_out");
        chk("one_out_addr1", 32'(rd_addr), 1);
        chk("one_out_gray", 32'(rd_grayptr), 1);

        // Full drain of 16 words, with two over-reads.
        hard_reset();
        set_w(16); tot_wr = 16;
        step(1'b0, 1'b0, "full");
        chk("full_level16", 32'(rd_level), 16);
        for (int i = 0; i < 18; i++) step(1'b1, 1'b0, "drain");
        chk("drain_gray_end", 32'(rd_grayptr), 24);
        chk("drain_addr_end", 32'(rd_addr), 0);
        chk("drain_reads", 32'(tot_rd), 16);
        chk("drain_uflow", 32'(rd_underflow), 1);

        // Underflow clear, and set winning over clear.
        step(1'b0, 1'b1, "uf_clr");
        chk("uf_cleared", 32'(rd_underflow), 0);
        step(1'b1, 1'b1, "uf_setwins");
        chk("uf_setwins_const", 32'(rd_underflow), 1);
        step(1'b0, 1'b1, "uf_clr2");

        // Randomized wrap: 40 more words with interleaved reads.
        wp = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (wp >= 40 && m_empty == 1) break;
            if (wp < 40 && ((m_w - m_r + 32) % 32) < 16 && $urandom_range(0, 1) == 1) begin
                set_w(m_w + 1);
                tot_wr++;
                wp++;
            end
            prev_g = rd_grayptr;
            step(($urandom_range(0, 2) != 0), ($urandom_range(0, 7) == 0), "wrap");
            chk("wrap_lvl_tot", 32'(rd_level), tot_wr - tot_rd);
            if (last_acc == 1) chk("wrap_gray_1bit", 32'($countones(prev_g ^ rd_grayptr)), 1);
        end
        chk("wrap_all_read", 32'(tot_rd), tot_wr);
        chk("wrap_empty_end", 32'(rd_empty), 1);

        // Concurrent write arrival with a read at level 1.
        set_w(m_w + 1); tot_wr++;
        step(1'b0, 1'b0, "conc_pre");
        set_w(m_w + 1); tot_wr++;
        step(1'b1, 1'b0, "conc");
        chk("conc_empty0", 32'(rd_empty), 0);
        chk("conc_level1", 32'(rd_level), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rd_ptr_empty.md
Name: rd_ptr_empty

Overview:
Read-side pointer and status logic for the dual-clock asynchronous FIFO, in the read clock domain. It is the counterpart of the write-pointer/full block. It keeps the binary read pointer, which addresses the FIFO RAM, and a registered Gray read pointer, which is exported to the write domain for full detection. It compares its own next Gray pointer against the Gray write pointer, already synchronized into this domain, to produce registered empty, almost-empty, fill-level and sticky-underflow status.

Parameters:
ADDRSIZE, 4, RAM address width; FIFO depth = 2^ADDRSIZE; pointers are ADDRSIZE+1 bits.
AE_THRESH, 2, almost-empty threshold in words; legal range 0..2^ADDRSIZE.

Ports:
rd_clk  input  1  read-domain clock
rd_rst_n  input  1  asynchronous active-low reset
rd_en  input  1  read request for the current cycle
rq2_wr_ptr  input  ADDRSIZE+1  Gray write pointer after the 2-flop synchronizer into rd_clk
underflow_clr  input  1  clears rd_underflow
rd_addr  output  ADDRSIZE  RAM read address
rd_grayptr  output  ADDRSIZE+1  registered Gray read pointer, sent to the write-domain synchronizer
rd_empty  output  1  FIFO empty, registered
rd_almost_empty  output  1  fill level <= AE_THRESH, registered
rd_level  output  ADDRSIZE+1  words available, registered, 0..2^ADDRSIZE
rd_underflow  output  1  sticky: a read was attempted while empty

Behaviour:
- One clock (rd_clk). Reset is asynchronous, active-low (rd_rst_n). All state registers use posedge rd_clk or negedge rd_rst_n.
- Reset values:
  - rd_ptr = 0, rd_grayptr = 0, rd_addr = 0.
  - rd_empty = 1, rd_almost_empty = 1, rd_level = 0, rd_underflow = 0.
- Reset mid-operation returns every output to its reset value immediately, without waiting for a clock edge.
- Read accept: rd_inc = rd_en & ~rd_empty. A read while empty is ignored; the pointer does not move.
- Next pointers:
  - rd_ptr_next = rd_ptr + rd_inc, modulo 2^(ADDRSIZE+1), wrapping naturally.
  - rd_gray_next = (rd_ptr_next >> 1) ^ rd_ptr_next.
  - rd_ptr and rd_grayptr register these values every cycle. Gray output is glitch-free: at most 1 bit changes per cycle.
- rd_addr = rd_ptr[ADDRSIZE-1:0], combinational from the register. The RAM data at rd_addr is the word read on the cycle rd_inc = 1.
- Empty:
  - rd_empty <= (rd_gray_next == rq2_wr_ptr).
  - Empty asserts on the same edge that consumes the last word.
  - Empty deasserts one rd_clk after a changed rq2_wr_ptr is presented.
  - Total write-to-not-empty latency is 3 rd_clk edges including the synchronizer; this latency is pessimistic but safe.
- Level:
  - wbin = Gray-to-binary of rq2_wr_ptr, using the XOR-prefix chain from the MSB down.
  - level_next = (wbin - rd_ptr_next) modulo 2^(ADDRSIZE+1).
  - rd_level <= level_next.
  - The full value 2^ADDRSIZE must be representable, which is why rd_level is ADDRSIZE+1 bits.
- Almost-empty: rd_almost_empty <= (level_next <= AE_THRESH).
  - With AE_THRESH = 0 it equals rd_empty.
  - Whenever rd_empty = 1, rd_almost_empty = 1.
- Underflow:
  - Set when rd_en & rd_empty.
  - Cleared when underflow_clr = 1.
  - If set and clear happen in the same cycle, set wins.
- Wrap-around: after 2^(ADDRSIZE+1) reads the pointer returns to 0. The MSB/Gray-MSB toggles distinguish full from empty; empty requires all bits equal.
- Simultaneous write arrival and last read: empty follows the compare on the post-read next pointer. No word is lost and none is read twice.
- Bounded operation: rd_level never exceeds 2^ADDRSIZE, provided the write side honours its full flag.

Test Plan:
ADDRSIZE=4, AE_THRESH=2 for all scenarios.
- Reset: assert rd_rst_n=0 mid-stream with rd_level=5 -> outputs go immediately to rd_empty=1, rd_almost_empty=1, rd_level=0, rd_addr=0, rd_grayptr=0, rd_underflow=0.
- Single word: drive rq2_wr_ptr 00000->00001 -> next edge gives rd_empty=0, rd_level=1, rd_almost_empty=1. Then rd_en for 1 cycle -> rd_addr=1, rd_grayptr=00001, rd_empty=1, rd_level=0.
- Full drain: rq2_wr_ptr=Gray(16)=11000, then rd_en held for 18 cycles -> exactly 16 reads accepted, rd_addr runs 0..15 and back to 0, rd_grayptr ends at 11000. rd_almost_empty rises when rd_level reaches 2 and rd_empty rises after read 16. rd_underflow=1 from cycle 17.
- Underflow clear: with rd_underflow=1, pulse underflow_clr with rd_en=0 -> rd_underflow=0. Pulse underflow_clr together with rd_en while empty -> rd_underflow stays 1.
- Wrap: cycle 40 words through by stepping rq2_wr_ptr in Gray, with reads interleaved -> rd_ptr wraps past 31 to 0, rd_grayptr changes exactly 1 bit per accepted read, and rd_level always equals writes minus reads.
- Concurrent: rd_level=1, a new write pointer arrives on the same cycle as rd_en -> rd_empty stays 0 and rd_level stays 1.
